pipe_stage_reg: RTL and testbench

//  Parametrised pipeline stage register for the CPU datapath (IF/ID, ID/EX, EX/MEM, MEM/WB).

---
 rtl/pipe_stage_reg.sv | 133 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with optional skid entry and flush.
// Optional performance counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CTRL_W = 7,
  parameter int unsigned SKID   = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [1:0]        occupancy_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  logic              main_v_q, main_v_d;
  logic              skid_v_q, skid_v_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
  logic              acc;
  logic              iss;

  // With a skid entry, ready depends only on a flop; without it,
  // a full main entry can still take data when it drains this cycle.
  assign in_ready_o = (SKID != 0) ? ~skid_v_q
                                  : (~main_v_q | out_ready_i);

  assign acc = in_valid_i & in_ready_o;
  assign iss = main_v_q & out_ready_i;

  assign out_valid_o = main_v_q;
  assign out_data_o  = main_data_q;
  assign out_ctrl_o  = main_v_q ? main_ctrl_q : '0;
  assign occupancy_o = {1'b0, main_v_q} + {1'b0, skid_v_q};

  // Next-state for the main/skid entries; flush wins over any accept.
  always_comb begin
    main_v_d    = main_v_q;
    skid_v_d    = skid_v_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush_i) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (iss) begin
      if (skid_v_q) begin
        main_data_d = skid_data_q;
        main_ctrl_d = skid_ctrl_q;
        skid_v_d    = 1'b0;
      end else if (acc) begin
        main_data_d = in_data_i;
        main_ctrl_d = in_ctrl_i;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (acc) begin
      if (main_v_q) begin
        skid_v_d    = 1'b1;
        skid_data_d = in_data_i;
        skid_ctrl_d = in_ctrl_i;
      end else begin
        main_v_d    = 1'b1;
        main_data_d = in_data_i;
        main_ctrl_d = in_ctrl_i;
      end
    end
  end

  // Entry registers; reset clears everything, including payload.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      main_v_q    <= 1'b0;
      skid_v_q    <= 1'b0;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      main_v_q    <= main_v_d;
      skid_v_q    <= skid_v_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  // Saturating stall and bubble counters; only reset clears them.
  always_comb begin
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (main_v_q && !out_ready_i && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (!main_v_q && !(&bubble_cnt_q))
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt_o  = stall_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;
`else
  assign stall_cnt_o  = '0;
  assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: skid, no-skid and
// narrow-counter instances share one stimulus stream.
module tb_pipe_stage_reg;

`ifdef PIPE_STAGE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst, flush, iv, ordy;
  logic [127:0] din;
  logic [6:0]   cin;

  logic         a_rdy, a_v;
  logic [127:0] a_d;
  logic [6:0]   a_c;
  logic [1:0]   a_occ;
  logic [15:0]  a_st, a_bu;

  logic         b_rdy, b_v;
  logic [127:0] b_d;
  logic [6:0]   b_c;
  logic [1:0]   b_occ;
  logic [15:0]  b_st, b_bu;

  logic         c_rdy, c_v;
  logic [127:0] c_d;
  logic [6:0]   c_c;
  logic [1:0]   c_occ;
  logic [3:0]   c_st, c_bu;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DATA_W(128), .CTRL_W(7), .SKID(1), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(iv), .in_ready_o(a_rdy),
    .in_data_i(din), .in_ctrl_i(cin),
    .out_valid_o(a_v), .out_ready_i(ordy),
    .out_data_o(a_d), .out_ctrl_o(a_c),
    .occupancy_o(a_occ),
    .stall_cnt_o(a_st), .bubble_cnt_o(a_bu)
  );

  pipe_stage_reg #(.DATA_W(128), .CTRL_W(7), .SKID(0), .CNT_W(16)) u_d0 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(iv), .in_ready_o(b_rdy),
    .in_data_i(din), .in_ctrl_i(cin),
    .out_valid_o(b_v), .out_ready_i(ordy),
    .out_data_o(b_d), .out_ctrl_o(b_c),
    .occupancy_o(b_occ),
    .stall_cnt_o(b_st), .bubble_cnt_o(b_bu)
  );

  pipe_stage_reg #(.DATA_W(128), .CTRL_W(7), .SKID(1), .CNT_W(4)) u_c4 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .in_valid_i(iv), .in_ready_o(c_rdy),
    .in_data_i(din), .in_ctrl_i(cin),
    .out_valid_o(c_v), .out_ready_i(ordy),
    .out_data_o(c_d), .out_ctrl_o(c_c),
    .occupancy_o(c_occ),
    .stall_cnt_o(c_st), .bubble_cnt_o(c_bu)
  );

  typedef struct {
    logic       rst;
    logic       fl;
    logic       iv;
    logic [7:0] d;
    logic [6:0] c;
    logic       ordy;
    logic       ev;
    logic [7:0] ed;
    logic [6:0] ec;
    logic [1:0] eocc;
    logic       erdy;
  } vec_t;

  vec_t tbl[21];

  task automatic chk(input string n, input logic [127:0] a,
                     input logic [127:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic v,
                       input logic [7:0] d, input logic [6:0] c,
                       input logic o);
    rst   = r;
    flush = f;
    iv    = v;
    din   = {120'd0, d};
    cin   = c;
    ordy  = o;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 8'h00, 7'h00, 1'b1);

    //         rst   fl    iv    d      c       ordy | ev  ed     ec     occ   rdy
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 7'h00, 1'b1, 1'b0, 8'h00, 7'h00, 2'd0, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 8'h00, 7'h00, 1'b1, 1'b0, 8'h00, 7'h00, 2'd0, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 1'b1, 8'h11, 7'h01, 1'b1, 1'b1, 8'h11, 7'h01, 2'd1, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'h22, 7'h02, 1'b1, 1'b1, 8'h22, 7'h02, 2'd1, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 8'h33, 7'h7F, 1'b1, 1'b1, 8'h33, 7'h7F, 2'd1, 1'b1};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 7'h00, 1'b1, 1'b0, 8'h33, 7'h00, 2'd0, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b1, 8'h44, 7'h04, 1'b0, 1'b1, 8'h44, 7'h04, 2'd1, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 8'h55, 7'h05, 1'b0, 1'b1, 8'h44, 7'h04, 2'd2, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 8'h66, 7'h06, 1'b0, 1'b1, 8'h44, 7'h04, 2'd2, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 7'h00, 1'b1, 1'b1, 8'h55, 7'h05, 2'd1, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 7'h00, 1'b1, 1'b0, 8'h55, 7'h00, 2'd0, 1'b1};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 8'h77, 7'h06, 1'b0, 1'b1, 8'h77, 7'h06, 2'd1, 1'b1};
    tbl[12] = '{1'b0, 1'b0, 1'b1, 8'h88, 7'h07, 1'b0, 1'b1, 8'h77, 7'h06, 2'd2, 1'b0};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 8'h99, 7'h09, 1'b0, 1'b0, 8'h77, 7'h00, 2'd0, 1'b1};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 8'h00, 7'h00, 1'b1, 1'b0, 8'h77, 7'h00, 2'd0, 1'b1};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 8'hAA, 7'h0A, 1'b1, 1'b1, 8'hAA, 7'h0A, 2'd1, 1'b1};
    tbl[16] = '{1'b0, 1'b1, 1'b1, 8'hBB, 7'h0B, 1'b1, 1'b0, 8'hAA, 7'h00, 2'd0, 1'b1};
    tbl[17] = '{1'b0, 1'b0, 1'b1, 8'hCC, 7'h0C, 1'b0, 1'b1, 8'hCC, 7'h0C, 2'd1, 1'b1};
    tbl[18] = '{1'b0, 1'b0, 1'b1, 8'hDD, 7'h0D, 1'b0, 1'b1, 8'hCC, 7'h0C, 2'd2, 1'b0};
    tbl[19] = '{1'b1, 1'b1, 1'b1, 8'hEE, 7'h0E, 1'b0, 1'b0, 8'h00, 7'h00, 2'd0, 1'b1};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 8'h00, 7'h00, 1'b1, 1'b0, 8'h00, 7'h00, 2'd0, 1'b1};

    for (int i = 0; i < 21; i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].fl, tbl[i].iv,
            tbl[i].d, tbl[i].c, tbl[i].ordy);
      tick();
      chk($sformatf("v%0d.valid", i), 128'(a_v), 128'(tbl[i].ev));
      chk($sformatf("v%0d.data", i), a_d, 128'(tbl[i].ed));
      chk($sformatf("v%0d.ctrl", i), 128'(a_c), 128'(tbl[i].ec));
      chk($sformatf("v%0d.occ", i), 128'(a_occ), 128'(tbl[i].eocc));
      chk($sformatf("v%0d.in_ready", i), 128'(a_rdy), 128'(tbl[i].erdy));
      if (tbl[i].rst) begin
        chk($sformatf("v%0d.stall_rst", i), 128'(a_st), 128'd0);
        chk($sformatf("v%0d.bubble_rst", i), 128'(a_bu), 128'd0);
      end
    end

    // Without a skid entry, ready follows out_ready_i in the same cycle.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 7'h00, 1'b1);
    tick();
    chk("s0.rst_ready", 128'(b_rdy), 128'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 8'h31, 7'h11, 1'b0);
    tick();
    chk("s0.valid", 128'(b_v), 128'd1);
    chk("s0.data", b_d, 128'h31);
    chk("s0.ready_stall", 128'(b_rdy), 128'd0);
    drive(1'b0, 1'b0, 1'b1, 8'h32, 7'h12, 1'b1);
    #1;
    chk("s0.ready_comb", 128'(b_rdy), 128'd1);
    tick();
    chk("s0.data_next", b_d, 128'h32);
    chk("s0.occ", 128'(b_occ), 128'd1);
    drive(1'b0, 1'b0, 1'b1, 8'h33, 7'h13, 1'b0);
    #1;
    chk("s0.ready_drop", 128'(b_rdy), 128'd0);
    tick();
    chk("s0.hold_data", b_d, 128'h32);
    chk("s0.hold_ctrl", 128'(b_c), 128'h12);
    chk("s0.occ_max", 128'(b_occ), 128'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 7'h00, 1'b1);
    tick();
    chk("s0.drain_valid", 128'(b_v), 128'd0);
    chk("s0.drain_ctrl", 128'(b_c), 128'd0);

    // Counters: 3 idle, 1 accept cycle (idle output), then stalls.
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 7'h00, 1'b1);
    tick();
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 7'h00, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("perf.bubble3", 128'(a_bu), PERF ? 128'd3 : 128'd0);
    chk("perf.stall0", 128'(a_st), 128'd0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 8'h5A, 7'h15, 1'b0);
    tick();
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 8'h00, 7'h00, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("perf.stall5", 128'(a_st), PERF ? 128'd5 : 128'd0);
    chk("perf.bubble4", 128'(a_bu), PERF ? 128'd4 : 128'd0);
    chk("perf.hold_data", a_d, 128'h5A);
    repeat (15) @(posedge clk);
    #1;
    chk("perf.stall20", 128'(a_st), PERF ? 128'd20 : 128'd0);
    chk("perf.sat15", 128'(c_st), PERF ? 128'd15 : 128'd0);
    chk("perf.c4_bubble", 128'(c_bu), PERF ? 128'd4 : 128'd0);

    // Flush leaves the counters alone.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 8'h00, 7'h00, 1'b0);
    tick();
    chk("perf.flush_valid", 128'(a_v), 128'd0);
    chk("perf.flush_keep", 128'(a_st), PERF ? 128'd21 : 128'd0);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 8'h00, 7'h00, 1'b1);
    tick();
    chk("perf.rst_stall", 128'(c_st), 128'd0);
    chk("perf.rst_bubble", 128'(a_bu), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
